// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the DMA channel abort supervisor.
// Imported by the per-channel FSM and the top level.
package dma_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2,
    REPORT = 2'd3
  } dma_abort_state_t;

  localparam logic [1:0] DMA_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] DMA_ERR_SW      = 2'b10;

endpackage

// File: rtl/dma_abort_channel_fsm.sv
// One supervised channel: transfer FSM, no-progress counter,
// abort hold timer and the captured error payload.
module dma_abort_channel_fsm
  import dma_ctrl_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 16,
  parameter int ABORT_HOLD    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [TIMEOUT_WIDTH-1:0] i_timeout_limit,
  input  logic                     i_desc_rd,
  input  logic [7:0]               i_desc_id,
  input  logic                     i_progress,
  input  logic                     i_resp_wr,
  input  logic                     i_sw_abort,
  input  logic                     i_grant,
  input  logic                     i_ack,
  output logic                     o_req,
  output logic                     o_abort,
  output logic                     o_busy,
  output logic [1:0]               o_code,
  output logic [7:0]               o_desc_id
);

  localparam int HW = (ABORT_HOLD > 1) ? $clog2(ABORT_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(ABORT_HOLD - 1);

  dma_abort_state_t         r_state, w_state_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [HW-1:0]            r_hold, w_hold_nxt;
  logic [7:0]               r_id, w_id_nxt;
  logic [1:0]               r_code, w_code_nxt;
  logic                     r_granted, w_granted_nxt;
  logic                     r_abort, w_abort_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     w_timeout, w_hold_last;

  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + TIMEOUT_WIDTH'(1);
  assign w_timeout   = (i_timeout_limit != '0) &&
                       (w_cnt_inc == i_timeout_limit);
  assign w_hold_last = (r_hold == HOLD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_id      <= '0;
      r_code    <= '0;
      r_granted <= 1'b0;
      r_abort   <= 1'b0;
      r_busy    <= 1'b0;
    end else if (i_en) begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_id      <= w_id_nxt;
      r_code    <= w_code_nxt;
      r_granted <= w_granted_nxt;
      r_abort   <= w_abort_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Counter holds the no-progress cycles seen before the current one.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_id_nxt      = r_id;
    w_code_nxt    = r_code;
    w_granted_nxt = r_granted | i_grant;
    unique case (r_state)
      IDLE: begin
        if (i_desc_rd) begin
          w_state_nxt = ACTIVE;
          w_id_nxt    = i_desc_id;
          w_cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (i_resp_wr) begin
          w_state_nxt = IDLE;
        end else if (i_sw_abort) begin
          w_state_nxt = ABORT;
          w_code_nxt  = DMA_ERR_SW;
          w_hold_nxt  = '0;
        end else if (w_timeout) begin
          w_state_nxt = ABORT;
          w_code_nxt  = DMA_ERR_TIMEOUT;
          w_hold_nxt  = '0;
        end else begin
          w_cnt_nxt = i_progress ? '0 : w_cnt_inc;
        end
      end
      ABORT: begin
        if (w_hold_last) w_state_nxt = REPORT;
        else w_hold_nxt = r_hold + HW'(1);
      end
      REPORT: begin
        if (i_ack) begin
          w_state_nxt   = IDLE;
          w_granted_nxt = 1'b0;
        end
      end
    endcase
  end

  // Request already in the last abort cycle so the report lands next cycle.
  always_comb begin
    o_req = ((r_state == REPORT) && !r_granted) ||
            ((r_state == ABORT) && w_hold_last);
    w_abort_nxt = (w_state_nxt == ABORT);
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  assign o_abort   = r_abort;
  assign o_busy    = r_busy;
  assign o_code    = r_code;
  assign o_desc_id = r_id;

endmodule

// File: rtl/dma_channel_abort_ctrl.sv
// Multi-channel transfer supervisor: per-channel abort FSMs plus a
// round-robin shared error report port.
module dma_channel_abort_ctrl
  import dma_ctrl_pkg::*;
#(
  parameter int APB_STR_CHA   = 2,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int ABORT_HOLD    = 4,
  localparam int CW = (APB_STR_CHA > 1) ? $clog2(APB_STR_CHA) : 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     aenable,
  input  logic [TIMEOUT_WIDTH-1:0] i_timeout_limit,
  input  logic [APB_STR_CHA-1:0]   i_desc_rd,
  input  logic [7:0]               i_desc_id,
  input  logic [APB_STR_CHA-1:0]   i_progress,
  input  logic [APB_STR_CHA-1:0]   i_resp_wr,
  input  logic [APB_STR_CHA-1:0]   i_sw_abort,
  output logic [APB_STR_CHA-1:0]   o_abort,
  output logic [APB_STR_CHA-1:0]   o_busy,
  output logic                     o_err_valid,
  output logic [CW-1:0]            o_err_ch,
  output logic [1:0]               o_err_code,
  output logic [7:0]               o_err_desc_id,
  input  logic                     i_err_ready
);

  logic [APB_STR_CHA-1:0] w_req, w_grant, w_ack;
  logic [1:0]             w_code [APB_STR_CHA];
  logic [7:0]             w_id   [APB_STR_CHA];
  logic [CW-1:0]          r_ptr, w_sel, w_ptr_nxt;
  logic                   w_any, w_free, w_fire, w_accept;
  logic                   r_err_valid;
  logic [CW-1:0]          r_err_ch;
  logic [1:0]             r_err_code;
  logic [7:0]             r_err_id;

  for (genvar c = 0; c < APB_STR_CHA; c++) begin : g_ch
    assign w_grant[c] = w_fire && (w_sel == CW'(c));
    assign w_ack[c]   = w_accept && (r_err_ch == CW'(c));
    dma_abort_channel_fsm #(
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .ABORT_HOLD    (ABORT_HOLD)
    ) u_fsm (
      .i_clk           (aclk),
      .i_rst           (areset),
      .i_en            (aenable),
      .i_timeout_limit (i_timeout_limit),
      .i_desc_rd       (i_desc_rd[c]),
      .i_desc_id       (i_desc_id),
      .i_progress      (i_progress[c]),
      .i_resp_wr       (i_resp_wr[c]),
      .i_sw_abort      (i_sw_abort[c]),
      .i_grant         (w_grant[c]),
      .i_ack           (w_ack[c]),
      .o_req           (w_req[c]),
      .o_abort         (o_abort[c]),
      .o_busy          (o_busy[c]),
      .o_code          (w_code[c]),
      .o_desc_id       (w_id[c])
    );
  end

  assign w_accept = r_err_valid & i_err_ready;
  assign w_free   = !r_err_valid | i_err_ready;
  assign w_fire   = aenable & w_free & w_any;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < APB_STR_CHA; i++) begin
      if (!w_any && w_req[(int'(r_ptr) + i) % APB_STR_CHA]) begin
        w_any = 1'b1;
        w_sel = CW'((int'(r_ptr) + i) % APB_STR_CHA);
      end
    end
    w_ptr_nxt = (w_sel == CW'(APB_STR_CHA - 1)) ? '0 : w_sel + CW'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ptr       <= '0;
      r_err_valid <= 1'b0;
      r_err_ch    <= '0;
      r_err_code  <= '0;
      r_err_id    <= '0;
    end else if (aenable) begin
      if (w_fire) begin
        r_err_valid <= 1'b1;
        r_err_ch    <= w_sel;
        r_err_code  <= w_code[w_sel];
        r_err_id    <= w_id[w_sel];
        r_ptr       <= w_ptr_nxt;
      end else if (w_accept) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign o_err_valid   = r_err_valid;
  assign o_err_ch      = r_err_ch;
  assign o_err_code    = r_err_code;
  assign o_err_desc_id = r_err_id;

endmodule

// File: doc/dma_channel_abort_ctrl.md
# dma_channel_abort_ctrl

Per-channel transfer supervisor for the multi-channel DMA scheduler. It tracks each APB stream channel from descriptor acceptance to response write and counts cycles without progress. It drives the channel's abort line on a timeout or a software abort request, then reports each aborted transfer through one shared, round-robin error channel. It sits beside the channel arbiters, and its `o_abort` vector feeds their `i_abort` inputs.

## Interface
- `APB_STR_CHA`, 2, number of supervised channels (1..8).
- `TIMEOUT_WIDTH`, 16, width of the no-progress counter and of the limit input.
- `ABORT_HOLD`, 4, number of cycles `o_abort` stays high per abort (≥1).

- `aclk`  in  1  clock; one clock domain.
- `areset`  in  1  reset; synchronous, active-high.
- `aenable`  in  1  global enable; while low, all state, counters and outputs hold.
- `i_timeout_limit`  in  TIMEOUT_WIDTH  no-progress cycle limit; 0 disables the timeout.
- `i_desc_rd`  in  [APB_STR_CHA] x 1  channel accepted a descriptor (1-cycle pulse).
- `i_desc_id`  in  8  ID of the descriptor being accepted; captured with `i_desc_rd`.
- `i_progress`  in  [APB_STR_CHA] x 1  channel completed an AXI-Lite or APB beat this cycle.
- `i_resp_wr`  in  [APB_STR_CHA] x 1  channel wrote its completion response.
- `i_sw_abort`  in  [APB_STR_CHA] x 1  software abort request (pulse).
- `o_abort`  out  [APB_STR_CHA] x 1  abort to the channel arbiter.
- `o_busy`  out  [APB_STR_CHA] x 1  channel is in ACTIVE, ABORT or REPORT.
- `o_err_valid`  out  1  error report valid.
- `o_err_ch`  out  $clog2(APB_STR_CHA) (min 1)  reporting channel.
- `o_err_code`  out  2  error code: 01 = timeout, 10 = software abort.
- `o_err_desc_id`  out  8  ID of the aborted descriptor.
- `i_err_ready`  in  1  error consumer ready.

## Operation
- Each channel runs its own FSM with states IDLE, ACTIVE, ABORT and REPORT.
- **IDLE**
  - `i_desc_rd[c]` → ACTIVE.
  - On that transition: capture `i_desc_id`, clear the counter.
  - `i_sw_abort`, `i_progress` and `i_resp_wr` are ignored in IDLE.
- **ACTIVE** (evaluated in priority order)
  1. `i_resp_wr` → IDLE (normal completion). This wins over a same-cycle timeout or `i_sw_abort`.
  2. `i_sw_abort` → ABORT, code 10.
  3. Timeout: counter == `i_timeout_limit` with limit ≠ 0 → ABORT, code 01.
  4. Otherwise, `i_progress` clears the counter. With no progress, the counter increments and saturates at all-ones.
- **ABORT**
  - `o_abort[c]` = 1 for exactly ABORT_HOLD enabled cycles, then → REPORT.
  - `i_resp_wr`, `i_sw_abort` and `i_desc_rd` are ignored.
- **REPORT**
  - The channel requests the shared error port. Once its report is accepted → IDLE.
- **Error port**
  - Round-robin among channels in REPORT. The pointer starts at channel 0; after each accept, the channel after the granted one gets highest priority.
  - A payload (`ch`, `code`, `desc_id`) is registered on grant and held stable until `o_err_valid && i_err_ready`.
  - After an accept, the next report may be valid in the following cycle.
- **`aenable` low**: FSM state, counters, hold counters, RR pointer and all outputs freeze. Inputs are not sampled.
- **`areset`** (including mid-transfer): every FSM → IDLE, counters = 0, RR pointer = 0, all outputs = 0. No report is generated for a transfer that reset interrupts.

## Timing
- All outputs are registered.
- Reset values: `o_abort`, `o_busy`, `o_err_valid`, `o_err_ch`, `o_err_code` and `o_err_desc_id` are all 0.
- `o_busy` rises 1 cycle after `i_desc_rd` and falls 1 cycle after `i_resp_wr` or after the report is accepted.
- **Timeout latency**: with `i_desc_rd` in cycle T and no progress afterwards, `o_abort` is high in cycles T+L+1 .. T+L+ABORT_HOLD, where L = limit.
- **Software abort**: with `i_sw_abort` in ACTIVE cycle T, `o_abort` is high in cycles T+1 .. T+ABORT_HOLD.
- **Report timing**: `o_err_valid` rises in the cycle after the last `o_abort` cycle, if the port is free. `o_err_valid` then stays high until accepted; the consumer may hold `i_err_ready` low indefinitely.
- A `i_progress` pulse in the cycle the counter equals the limit does not prevent the timeout.

## Structure
- Shared package `dma_ctrl_pkg`:
  - `dma_abort_state_t` enum: IDLE, ACTIVE, ABORT, REPORT.
  - Constants `DMA_ERR_TIMEOUT` = 2'b01 and `DMA_ERR_SW` = 2'b10.
- Sub-module `dma_abort_channel_fsm`: one instance per channel, generated. It contains the FSM, no-progress counter, hold counter, captured desc ID and code, and the report request/grant.
- The top level holds the round-robin grant logic and the error output register.

## Test plan
- **Normal completion**: limit = 5; `i_desc_rd[0]` at cycle 10 with id 0x3C; progress every 3 cycles; `i_resp_wr` at cycle 30 → no `o_abort`; `o_busy[0]` high cycles 11–30.
- **Timeout**: limit = 5, ABORT_HOLD = 4; `i_desc_rd[1]` at cycle 10 with id 0x7A; no progress → `o_abort[1]` high cycles 16–19; report ch = 1, code = 01, id = 0x7A valid from cycle 20.
- **Software abort plus simultaneous completion**:
  - `i_sw_abort[0]` and `i_resp_wr[0]` in the same ACTIVE cycle → IDLE, no abort.
  - A separate `i_sw_abort[0]` alone at cycle T → abort high T+1..T+4, code 10.
- **Arbitration with back-pressure**: both channels enter REPORT in the same cycle with `i_err_ready` = 0 for 5 cycles → ch 0 payload held stable; after its accept, ch 1 is valid in the next cycle; the RR pointer then favours ch 0.
- **Limit 0 and enable**:
  - limit = 0 with 1000 idle cycles in ACTIVE → no abort.
  - `aenable` low for 3 cycles during ABORT → `o_abort` high for 4 + 3 cycles total.
- **Reset mid-operation**: `areset` during ABORT and REPORT → all outputs 0 next cycle, no report ever issued.
